// File: rtl/rf_mport.sv
// rf_mport: multi-ported register file, youngest-wins writes, x0 hard-wired, registered bypassed reads
module rf_mport #(
   parameter int NUM_REGS = 32,
   parameter int DATA_LEN = 32,
   parameter int NUM_W_PORTS = 4,
   parameter int NUM_R_PORTS = 8,
   localparam int ADDR_W = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_W_PORTS-1:0]          wr_en,
   input  logic [NUM_W_PORTS*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_W_PORTS*DATA_LEN-1:0] wr_data,
   output logic [NUM_W_PORTS-1:0]          wr_drop,
   input  logic [NUM_R_PORTS-1:0]          rd_en,
   input  logic [NUM_R_PORTS*ADDR_W-1:0]   rd_addr,
   output logic [NUM_R_PORTS*DATA_LEN-1:0] rd_data,
   output logic [NUM_R_PORTS-1:0]          rd_valid
);
   logic [DATA_LEN-1:0] regs [NUM_REGS];
   logic [ADDR_W-1:0]   wa [NUM_W_PORTS];
   logic [DATA_LEN-1:0] wd [NUM_W_PORTS];
   logic [ADDR_W-1:0]   ra [NUM_R_PORTS];
   logic [DATA_LEN-1:0] byp [NUM_R_PORTS];
   logic [NUM_W_PORTS-1:0] commit;
   always_comb begin
      for (int i = 0; i < NUM_W_PORTS; i++) begin
         wa[i] = wr_addr[i*ADDR_W +: ADDR_W];
         wd[i] = wr_data[i*DATA_LEN +: DATA_LEN];
      end
      for (int i = 0; i < NUM_W_PORTS; i++) begin
         commit[i] = wr_en[i] && wa[i] != '0;
         for (int j = i + 1; j < NUM_W_PORTS; j++)
            if (wr_en[j] && wa[j] == wa[i]) commit[i] = 1'b0;
      end
   end
   assign wr_drop = wr_en & ~commit;
   // commits are unique per address, so at most one bypass term matches
   always_comb begin
      for (int p = 0; p < NUM_R_PORTS; p++) begin
         ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
         byp[p] = regs[ra[p]];
         for (int i = 0; i < NUM_W_PORTS; i++)
            if (commit[i] && wa[i] == ra[p]) byp[p] = wd[i];
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         rd_data <= '0;
         rd_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_W_PORTS; i++)
            if (commit[i]) regs[wa[i]] <= wd[i];
         for (int p = 0; p < NUM_R_PORTS; p++) begin
            rd_valid[p] <= rd_en[p];
            if (rd_en[p]) rd_data[p*DATA_LEN +: DATA_LEN] <= byp[p];
         end
      end
   end
endmodule

// File: tb/tb_rf_mport.sv
// tb_rf_mport: directed plus random scoreboard bench for rf_mport
module tb_rf_mport;
   localparam int NW = 4, NR = 8, AW = 5, DW = 32;
   logic clk = 1'b0, rst_n;
   logic [NW-1:0] wr_en, wr_drop;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR-1:0] rd_en, rd_valid;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   int passed = 0, total = 0;
   typedef struct {string tag; int port; logic [DW-1:0] data; logic valid;} exp_t;
   exp_t sb[$];
   logic [DW-1:0] mem [32];

   rf_mport dut (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_drop(wr_drop), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid));

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle();
      wr_en = '0;
      rd_en = '0;
   endtask

   task automatic wr(int l, int a, logic [DW-1:0] d);
      wr_en[l] = 1'b1;
      wr_addr[l*AW +: AW] = a[AW-1:0];
      wr_data[l*DW +: DW] = d;
   endtask

   task automatic expect_rd(string tag, int p, logic [DW-1:0] d, logic v);
      sb.push_back('{tag, p, d, v});
   endtask

   task automatic rd(string tag, int p, int a, logic [DW-1:0] d, logic v);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a[AW-1:0];
      expect_rd(tag, p, d, v);
   endtask

   task automatic drop(logic [NW-1:0] exp);
      #1;
      chk("wr_drop", {28'b0, wr_drop}, {28'b0, exp});
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, ".data"}, rd_data[e.port*DW +: DW], e.data);
         chk({e.tag, ".valid"}, {31'b0, rd_valid[e.port]}, {31'b0, e.valid});
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      idle();
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < NW; l++) wr(l, 5, 32'h1000 + l);
         for (int p = 0; p < NR; p++) rd("rst", p, 5, '0, 1'b0);
         drop(4'b0111);
         step();
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         for (int p = 0; p < NR; p++)
            if (c*8 + p + 1 <= 31) rd("clr", p, c*8 + p + 1, '0, 1'b1);
         step();
      end
      wr(0, 7, 32'hDEADBEEF);
      drop(4'b0000);
      expect_rd("idle3", 3, '0, 1'b0);
      step();
      rd("raw", 3, 7, 32'hDEADBEEF, 1'b1);
      step();
      wr(0, 9, 32'h11);
      wr(1, 9, 32'h22);
      wr(3, 9, 32'h44);
      wr_addr[2*AW +: AW] = 5'd9;
      drop(4'b0011);
      step();
      rd("youngest", 5, 9, 32'h44, 1'b1);
      step();
      wr(0, 4, 32'hA5);
      wr_addr[2*AW +: AW] = 5'd4;
      drop(4'b0000);
      step();
      rd("disabled", 1, 4, 32'hA5, 1'b1);
      step();
      wr(1, 0, 32'hFFFF_FFFF);
      rd("x0_byp", 2, 0, '0, 1'b1);
      drop(4'b0010);
      step();
      rd("x0", 6, 0, '0, 1'b1);
      step();
      wr(2, 12, 32'h1);
      step();
      wr(1, 12, 32'h55);
      rd("byp0", 0, 12, 32'h55, 1'b1);
      rd("byp1", 1, 12, 32'h55, 1'b1);
      rd("byp7", 7, 12, 32'h55, 1'b1);
      step();
      expect_rd("hold", 0, 32'h55, 1'b0);
      step();
      for (int l = 0; l < NW; l++) wr(l, 31, 32'hC0 + l);
      drop(4'b0111);
      step();
      rd("max", 4, 31, 32'hC3, 1'b1);
      step();
      for (int r = 0; r < 32; r++) mem[r] = '0;
      mem[7] = 32'hDEADBEEF;
      mem[9] = 32'h44;
      mem[4] = 32'hA5;
      mem[12] = 32'h55;
      mem[31] = 32'hC3;
      for (int it = 0; it < 20; it++) begin
         for (int l = 0; l < NW; l++) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(0, 31);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               wr(l, a, d);
               if (a != 0) mem[a] = d;
            end
         end
         for (int p = 0; p < NR; p++) begin
            int a;
            a = $urandom_range(0, 31);
            rd("rand", p, a, mem[a], 1'b1);
         end
         step();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
